tour_cmd_seq: RTL and testbench

- Parametrised successor to the tour-command translation stage of the knight's-tour robot; sits between the tour solver (move memory), the UART command path and cmd_proc.
- Idle: passes UART commands straight through to cmd_proc.
- After a solved tour is ready: replays the stored knight moves, forward or reversed, as two-leg movement commands with a full handshake.
- Adds depth parametrisation, reverse replay, configurable opcodes and illegal-move abort.

---
 rtl/tour_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - knight's-tour move replay and UART command passthrough to cmd_proc
module tour_cmd_seq #(
    parameter int         NUM_MOVES = 24,
    parameter logic [3:0] MV_OPC    = 4'h4,
    parameter logic [3:0] FAN_OPC   = 4'h5,
    localparam int        IW        = $clog2(NUM_MOVES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_tour,
    input  logic          rev,
    input  logic [7:0]    move,
    output logic [IW-1:0] mv_indx,
    input  logic [15:0]   cmd_UART,
    input  logic          cmd_rdy_UART,
    input  logic          clr_cmd_rdy,
    input  logic          send_resp,
    output logic [15:0]   cmd,
    output logic          cmd_rdy,
    output logic [7:0]    resp,
    output logic          busy,
    output logic          mv_err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOVES - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_ACK  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        LEG1,
        DONE1,
        LEG2,
        DONE2
    } state_t;

    state_t      state, state_n;
    logic        rev_q;
    logic [15:0] leg1, leg2;

    logic        ld_idx, step_idx, ld_leg, err_n;
    logic [1:0]  dx_mag, dy_mag;
    logic        dx_neg, dy_neg;
    logic        one_hot;
    logic        is_last;
    logic [15:0] leg1_d, leg2_d;

    // Magnitude and sign of each leg for the forward direction
    always_comb begin
        dx_mag = 2'd0;
        dy_mag = 2'd0;
        dx_neg = 1'b0;
        dy_neg = 1'b0;
        case (move)
            8'h01: begin dx_mag = 2'd1; dy_mag = 2'd2;                                 end
            8'h02: begin dx_mag = 2'd1; dy_mag = 2'd2; dx_neg = 1'b1;                  end
            8'h04: begin dx_mag = 2'd2; dy_mag = 2'd1; dx_neg = 1'b1;                  end
            8'h08: begin dx_mag = 2'd2; dy_mag = 2'd1; dx_neg = 1'b1; dy_neg = 1'b1;   end
            8'h10: begin dx_mag = 2'd1; dy_mag = 2'd2; dx_neg = 1'b1; dy_neg = 1'b1;   end
            8'h20: begin dx_mag = 2'd1; dy_mag = 2'd2;                dy_neg = 1'b1;   end
            8'h40: begin dx_mag = 2'd2; dy_mag = 2'd1;                dy_neg = 1'b1;   end
            8'h80: begin dx_mag = 2'd2; dy_mag = 2'd1;                                 end
            default: begin dx_mag = 2'd0; dy_mag = 2'd0;                               end
        endcase
    end

    assign one_hot = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);

    // Reverse replay undoes each move, so both components flip sign
    assign leg1_d = {MV_OPC,  ((dy_neg ^ rev_q) ? HDG_SOUTH : HDG_NORTH), 2'b00, dy_mag};
    assign leg2_d = {FAN_OPC, ((dx_neg ^ rev_q) ? HDG_WEST  : HDG_EAST),  2'b00, dx_mag};

    assign is_last = rev_q ? (mv_indx == '0) : (mv_indx == LAST_IDX);

    always_comb begin
        state_n  = state;
        ld_idx   = 1'b0;
        step_idx = 1'b0;
        ld_leg   = 1'b0;
        err_n    = 1'b0;
        cmd      = leg1;
        cmd_rdy  = 1'b0;
        resp     = RESP_ACK;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
                if (start_tour) begin
                    ld_idx  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                if (!one_hot) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    ld_leg  = 1'b1;
                    state_n = LEG1;
                end
            end
            LEG1: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_n = DONE1;
            end
            DONE1: begin
                if (send_resp) state_n = LEG2;
            end
            LEG2: begin
                cmd     = leg2;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_n = DONE2;
            end
            DONE2: begin
                cmd = leg2;
                // The final acknowledgement doubles as the tour-complete byte
                if (is_last) resp = RESP_DONE;
                if (send_resp) begin
                    if (is_last) begin
                        state_n = IDLE;
                    end else begin
                        step_idx = 1'b1;
                        state_n  = FETCH;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
            rev_q   <= 1'b0;
            busy    <= 1'b0;
            mv_err  <= 1'b0;
            leg1    <= 16'h0000;
            leg2    <= 16'h0000;
        end else begin
            state  <= state_n;
            busy   <= (state_n != IDLE);
            mv_err <= err_n;
            if (ld_idx) begin
                rev_q   <= rev;
                mv_indx <= rev ? LAST_IDX : '0;
            end else if (step_idx) begin
                mv_indx <= rev_q ? (mv_indx - ONE_IDX) : (mv_indx + ONE_IDX);
            end
            if (ld_leg) begin
                leg1 <= leg1_d;
                leg2 <= leg2_d;
            end
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - directed scoreboard bench for tour_cmd_seq with a 4-move memory
module tb_tour_cmd_seq;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic        rev;
    logic [7:0]  move;
    logic [1:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        mv_err;

    logic [7:0]  mem [N];
    logic [17:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    tour_cmd_seq #(.NUM_MOVES(N), .MV_OPC(4'h4), .FAN_OPC(4'h5)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .rev(rev), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .resp(resp), .busy(busy), .mv_err(mv_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) move <= mem[mv_indx];

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_legs(input logic [7:0] m, input logic r);
        int dx, dy;
        logic [7:0] hv, hh;
        logic [3:0] mv, mh;
        case (m)
            8'h01: begin dx =  1; dy =  2; end
            8'h02: begin dx = -1; dy =  2; end
            8'h04: begin dx = -2; dy =  1; end
            8'h08: begin dx = -2; dy = -1; end
            8'h10: begin dx = -1; dy = -2; end
            8'h20: begin dx =  1; dy = -2; end
            8'h40: begin dx =  2; dy = -1; end
            default: begin dx = 2; dy = 1; end
        endcase
        if (r) begin dx = -dx; dy = -dy; end
        hv = (dy > 0) ? 8'h00 : 8'h7F;
        hh = (dx > 0) ? 8'hBF : 8'h3F;
        mv = 4'((dy < 0) ? -dy : dy);
        mh = 4'((dx < 0) ? -dx : dx);
        return {4'h4, hv, mv, 4'h5, hh, mh};
    endfunction

    task automatic push_tour(input logic r);
        logic [31:0] l;
        int i;
        for (int k = 0; k < N; k++) begin
            i = r ? (N - 1 - k) : k;
            l = exp_legs(mem[i], r);
            exp_q.push_back({2'(i), l[31:16]});
            exp_q.push_back({2'(i), l[15:0]});
        end
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (cmd_rdy === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("cmd_rdy_timeout", 32'(cmd_rdy), 32'd1);
    endtask

    task automatic pop_check();
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("leg_cmd", 32'(cmd), 32'(e[15:0]));
        check("leg_idx", 32'(mv_indx), 32'(e[17:16]));
        check("leg_busy", 32'(busy), 32'd1);
    endtask

    task automatic serve_leg(input bit second, input bit last);
        bit ok;
        wait_rdy(ok);
        if (!ok) return;
        pop_check();
        if (second) begin
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
            check("early_resp_ignored", 32'(cmd_rdy), 32'd1);
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("rdy_drop", 32'(cmd_rdy), 32'd0);
        check("resp_byte", 32'(resp), (second && last) ? 32'hA5 : 32'h5A);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic start(input logic r);
        rev = r;
        start_tour = 1'b1;
        push_tour(r);
        @(negedge clk);
        start_tour = 1'b0;
        rev = 1'b0;
        check("lat1_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        check("lat2_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        check("lat3_rdy", 32'(cmd_rdy), 32'd1);
        check("first_idx", 32'(mv_indx), r ? 32'd3 : 32'd0);
    endtask

    task automatic run_tour(input logic r, input bit poke);
        start(r);
        for (int k = 0; k < N; k++) begin
            if (poke && k == 1) begin
                rev = ~r;
                start_tour = 1'b1;
                @(negedge clk);
                start_tour = 1'b0;
                rev = 1'b0;
            end
            serve_leg(1'b0, 1'b0);
            serve_leg(1'b1, k == N - 1);
            if (k == 0 && !r) check("step_to_1", 32'(mv_indx), 32'd1);
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_cmd_pass", 32'(cmd), 32'(cmd_UART));
        check("end_rdy_pass", 32'(cmd_rdy), 32'(cmd_rdy_UART));
        check("end_resp", 32'(resp), 32'hA5);
    endtask

    initial begin
        int  err_pulses;
        bit  rdy_seen;
        bit  ok;
        rst = 1'b1; start_tour = 1'b0; rev = 1'b0;
        cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h10; mem[3] = 8'h40;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(mv_indx), 32'd0);
        check("rst_err", 32'(mv_err), 32'd0);
        check("rst_rdy", 32'(cmd_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
        #1;
        check("idle_cmd", 32'(cmd), 32'h2000);
        check("idle_rdy", 32'(cmd_rdy), 32'd1);
        check("idle_resp", 32'(resp), 32'hA5);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        check("fwd_leg1_const", exp_legs(mem[0], 1'b0), 32'h4002_5BF1);
        cmd_UART = 16'h1234;
        run_tour(1'b0, 1'b1);
        cmd_rdy_UART = 1'b0;
        @(negedge clk);

        mem[3] = 8'h08;
        check("rev_leg_const", exp_legs(mem[3], 1'b1), 32'h4001_5BF2);
        run_tour(1'b1, 1'b0);
        @(negedge clk);

        mem[0] = 8'h03;
        err_pulses = 0;
        rdy_seen = 1'b0;
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (mv_err === 1'b1) err_pulses++;
            if (cmd_rdy === 1'b1) rdy_seen = 1'b1;
            if (n == 3) begin
                check("ill_err_high", 32'(mv_err), 32'd1);
                check("ill_busy", 32'(busy), 32'd0);
            end
            @(negedge clk);
        end
        check("ill_pulses", 32'(err_pulses), 32'd1);
        check("ill_no_rdy", 32'(rdy_seen), 32'd0);
        mem[0] = 8'h80;

        start(1'b0);
        serve_leg(1'b0, 1'b0);
        wait_rdy(ok);
        if (ok) pop_check();
        rst = 1'b1;
        #1;
        check("rst_mid_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_idx", 32'(mv_indx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_tour(1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
